hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard scheduler for the 5-stage MIPS core (F/D/E/M/W) that owns all GRF read hazards.
//  Tracks dst/Tnew of in-flight instructions in E/M/W, compares them against D-stage Tuse,
//  and drives the D stall plus D- and E-stage forward selects. W->D is covered by the GRF's
//  internal write-through bypass, so it is never forwarded here. Optionally sequences
//  mult/div busy time.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a mult/multu enters E
//  DIV_CYCLES   10  busy cycles after a div/divu enters E
//  CNT_W        4   MDU busy counter width; must hold DIV_CYCLES
// PORTS
//  clk          in   1  clock
//  reset        in   1  synchronous, active-high reset
//  d_rs, d_rt   in   5  D-stage source register numbers
//  d_tuse_rs    in   2  cycles after D until rs is consumed (branch 0, ALU 1, store-data 2)
//  d_tuse_rt    in   2  same for rt
//  d_dst        in   5  D-stage destination register (0 = none)
//  d_tnew       in   2  cycles after entering E until the result exists (jal 0, ALU 1, load 2); 3 illegal
//  d_wen        in   1  D-stage instruction writes the GRF
//  d_md_start   in   1  D instruction is mult/multu/div/divu
//  d_md_div     in   1  with d_md_start: 1 = div, 0 = mult
//  d_md_use     in   1  D instruction touches HI/LO or the MDU (includes d_md_start)
//  stall        out  1  freeze F/D, insert bubble into E
//  fwd_d_rs     out  2  D rs source: 0 GRF, 1 E result, 2 M result
//  fwd_d_rt     out  2  same for rt
//  fwd_e_rs     out  2  E rs source: 0 registered D value, 1 M result, 2 W result
//  fwd_e_rt     out  2  same for rt
//  md_busy      out  1  MDU counter nonzero
// BEHAVIOUR
//  - Records E, M, W each hold {dst, tnew, wen}; E also holds {rs, rt}. Reset clears all to 0,
//    giving stall=0, md_busy=0 and all fwd_* = 0 regardless of D inputs.
//  - Each posedge: W<=M, M<=E, each tnew decremented and saturated at 0.
//    E<=D record when stall=0; when stall=1, E<=bubble (all fields 0).
//  - Match(stage, r): r!=0 && stage.wen && stage.dst==r. A bubble never matches.
//  - stall_rs = Match(E,d_rs)&&E.tnew>d_tuse_rs || Match(M,d_rs)&&M.tnew>d_tuse_rs; stall_rt likewise.
//  - stall = stall_rs | stall_rt | stall_md. stall and all fwd_* are purely combinational, 0-cycle.
//  - fwd_d_*: 1 if Match(E)&&E.tnew==0; else 2 if Match(M)&&M.tnew==0; else 0. The nearer stage wins.
//    If the nearer stage matches with tnew!=0, the result is 0, not the older stage; stall covers it.
//  - fwd_e_*: uses E.rs/E.rt; 1 if Match(M)&&M.tnew==0; else 2 if Match(W); else 0.
//    W.tnew is always 0 by construction.
//  - fwd_* is computed even while stall=1; the datapath ignores fwd_d_* during a stall.
// CONFIGURATION
//  MDU_STALL_EN defined:
//  - cnt (CNT_W) resets to 0.
//  - On a posedge with d_md_start && !stall: cnt <= d_md_div ? DIV_CYCLES : MULT_CYCLES.
//  - Otherwise, if cnt!=0: cnt <= cnt-1.
//  - md_busy = (cnt!=0); stall_md = d_md_use && md_busy.
//  - A second md op back-to-back waits until cnt==0, then issues; the load takes priority over the decrement.
//  MDU_STALL_EN undefined: no counter, md_busy=0, stall_md=0, d_md_* ignored.
// TESTING
//  1 lw $8 (dst8,tnew2) then add rs=8 (tuse1) -> stall=1 for 1 cycle; E bubble; next cycle
//    stall=0, fwd_d_rs=0; one cycle later fwd_e_rs=2 (W).
//  2 addu $9 (tnew1) then beq rs=9 (tuse0) -> stall=1 for 1 cycle; then fwd_d_rs=2 (M), stall=0.
//  3 jal (dst31,tnew0) then jr rs=31 (tuse0) -> stall=0, fwd_d_rs=1 the same cycle.
//  4 writes to $0 (dst0,wen1,tnew2) followed by a reader of rs=0 -> stall=0, all fwd_*=0;
//    back-to-back writers of $5 -> the nearest (E) wins.
//  5 [MDU_STALL_EN] div, then mfhi every cycle -> md_busy high 10 cycles, mfhi stalled
//    until cnt==0; mult + mult -> second stalled 5 cycles.
//  6 reset asserted mid-stall (lw in E) and mid-div (cnt=7) -> next cycle all records 0,
//    cnt=0, stall=0, fwd_*=0.

Source files
------------

// File: rtl/hazard_if.sv
// D-stage hazard query bundle between the decode stage and the hazard scheduler.
// The master drives D-stage operand/destination info; the slave returns stall/forward selects.
interface hazard_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] d_dst;
  logic [1:0] d_tnew;
  logic       d_wen;
  logic       d_md_start;
  logic       d_md_div;
  logic       d_md_use;
  logic       stall;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;
  logic       md_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_wen,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_wen,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// GRF hazard scheduler for the 5-stage MIPS core: Tuse/Tnew stall plus D/E forward selects.
// Define MDU_STALL_EN to add the mult/div busy counter and its HI/LO stall.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hz
);

  // _p0 = E, _p1 = M, _p2 = W; vld_pN is the record's GRF write enable
  logic [4:0] dst_p0, dst_p1, dst_p2;
  logic [1:0] tnew_p0, tnew_p1, tnew_p2;
  logic       vld_p0, vld_p1, vld_p2;
  logic [4:0] rs_p0, rt_p0;

  logic stall, stall_rs, stall_rt, stall_md, md_busy;
  logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
  logic me_hit_rs, me_hit_rt, we_hit_rs, we_hit_rt;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic hit(input logic vld, input logic [4:0] dst, input logic [4:0] r);
    return (r != 5'd0) && vld && (dst == r);
  endfunction

  function automatic logic need_stall(input logic eh, input logic [1:0] et,
                                      input logic mh, input logic [1:0] mt,
                                      input logic [1:0] tuse);
    return (eh && (et > tuse)) || (mh && (mt > tuse));
  endfunction

  // The nearest matching stage decides; a not-yet-ready E result blocks the older M value.
  function automatic logic [1:0] d_src(input logic eh, input logic [1:0] et,
                                       input logic mh, input logic [1:0] mt);
    if (eh)                      return (et == 2'd0) ? 2'd1 : 2'd0;
    else if (mh && mt == 2'd0)   return 2'd2;
    else                         return 2'd0;
  endfunction

  function automatic logic [1:0] e_src(input logic mh, input logic [1:0] mt, input logic wh);
    if (mh && mt == 2'd0) return 2'd1;
    else if (wh)          return 2'd2;
    else                  return 2'd0;
  endfunction

  // D -> E record capture; a stall injects a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_p0 <= '0; tnew_p0 <= '0; vld_p0 <= 1'b0; rs_p0 <= '0; rt_p0 <= '0;
      dst_p1 <= '0; tnew_p1 <= '0; vld_p1 <= 1'b0;
      dst_p2 <= '0; tnew_p2 <= '0; vld_p2 <= 1'b0;
    end else begin
      if (stall) begin
        dst_p0 <= '0; tnew_p0 <= '0; vld_p0 <= 1'b0; rs_p0 <= '0; rt_p0 <= '0;
      end else begin
        dst_p0  <= hz.d_dst;
        tnew_p0 <= hz.d_tnew;
        vld_p0  <= hz.d_wen;
        rs_p0   <= hz.d_rs;
        rt_p0   <= hz.d_rt;
      end
      // E -> M -> W, Tnew counting down toward availability
      dst_p1  <= dst_p0;  tnew_p1 <= tnew_dec(tnew_p0); vld_p1 <= vld_p0;
      dst_p2  <= dst_p1;  tnew_p2 <= tnew_dec(tnew_p1); vld_p2 <= vld_p1;
    end
  end

  always_comb begin
    e_hit_rs  = hit(vld_p0, dst_p0, hz.d_rs);
    e_hit_rt  = hit(vld_p0, dst_p0, hz.d_rt);
    m_hit_rs  = hit(vld_p1, dst_p1, hz.d_rs);
    m_hit_rt  = hit(vld_p1, dst_p1, hz.d_rt);
    me_hit_rs = hit(vld_p1, dst_p1, rs_p0);
    me_hit_rt = hit(vld_p1, dst_p1, rt_p0);
    we_hit_rs = hit(vld_p2, dst_p2, rs_p0);
    we_hit_rt = hit(vld_p2, dst_p2, rt_p0);
    stall_rs  = need_stall(e_hit_rs, tnew_p0, m_hit_rs, tnew_p1, hz.d_tuse_rs);
    stall_rt  = need_stall(e_hit_rt, tnew_p0, m_hit_rt, tnew_p1, hz.d_tuse_rt);
    stall     = stall_rs | stall_rt | stall_md;
  end

  assign hz.stall    = stall;
  assign hz.fwd_d_rs = d_src(e_hit_rs, tnew_p0, m_hit_rs, tnew_p1);
  assign hz.fwd_d_rt = d_src(e_hit_rt, tnew_p0, m_hit_rt, tnew_p1);
  assign hz.fwd_e_rs = e_src(me_hit_rs, tnew_p1, we_hit_rs);
  assign hz.fwd_e_rt = e_src(me_hit_rt, tnew_p1, we_hit_rt);
  assign hz.md_busy  = md_busy;

`ifdef MDU_STALL_EN
  logic [CNT_W-1:0] cnt;

  // A new op only issues when not stalled, so it always loads from cnt==0
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (hz.d_md_start && !stall)
      cnt <= hz.d_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign md_busy  = (cnt != '0);
  assign stall_md = hz.d_md_use && md_busy;
`else
  logic unused_md;
  assign unused_md = ^{hz.d_md_start, hz.d_md_div, hz.d_md_use};
  assign md_busy   = 1'b0;
  assign stall_md  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: an instruction-level model predicts stall/forwarding
// per cycle; a negedge monitor pops and compares against the DUT.
module tb_hazard_ctrl;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_if hz ();

  hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       wen, md_start, md_div, md_use;
  } instr_t;

  // An in-flight instruction: its age (cyc - enter) is 0 in E, 1 in M, 2 in W.
  typedef struct {
    logic [4:0] dst, rs, rt;
    int         tnew;
    logic       wen;
    int         enter;
  } fl_t;

  typedef struct {
    logic       stall;
    logic [1:0] fdrs, fdrt, fers, fert;
    logic       busy;
  } exp_t;

  fl_t  fl[$];
  exp_t sbq[$];
  int   cyc;
  int   md_free;
  int   checks;
  int   errors;

  function automatic int find(input int age);
    foreach (fl[i]) if (cyc - fl[i].enter == age) return i;
    return -1;
  endfunction

  function automatic int remain(input int idx);
    int r;
    r = fl[idx].tnew - (cyc - fl[idx].enter);
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit hits(input int idx, input logic [4:0] r);
    if (idx < 0) return 1'b0;
    return (r != 5'd0) && fl[idx].wen && (fl[idx].dst == r);
  endfunction

  function automatic bit need_stall(input logic [4:0] r, input logic [1:0] tuse);
    int ie, im;
    ie = find(0);
    im = find(1);
    return (hits(ie, r) && remain(ie) > int'(tuse)) || (hits(im, r) && remain(im) > int'(tuse));
  endfunction

  function automatic logic [1:0] d_src(input logic [4:0] r);
    int ie, im;
    ie = find(0);
    im = find(1);
    if (hits(ie, r)) return (remain(ie) == 0) ? 2'd1 : 2'd0;
    if (hits(im, r) && remain(im) == 0) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] e_src(input bit use_rt);
    int ie, im, iw;
    logic [4:0] r;
    ie = find(0);
    im = find(1);
    iw = find(2);
    if (ie < 0) return 2'd0;
    r = use_rt ? fl[ie].rt : fl[ie].rs;
    if (hits(im, r) && remain(im) == 0) return 2'd1;
    if (hits(iw, r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic model_busy();
`ifdef MDU_STALL_EN
    return cyc < md_free;
`else
    return 1'b0;
`endif
  endfunction

  function automatic instr_t mk(input int rs, input int tu_rs, input int rt, input int tu_rt,
                                input int dst, input int tnew, input bit wen,
                                input bit mds, input bit mdd, input bit mdu);
    instr_t x;
    x.rs = 5'(rs); x.tuse_rs = 2'(tu_rs); x.rt = 5'(rt); x.tuse_rt = 2'(tu_rt);
    x.dst = 5'(dst); x.tnew = 2'(tnew); x.wen = wen;
    x.md_start = mds; x.md_div = mdd; x.md_use = mdu;
    return x;
  endfunction

  task automatic drive(input instr_t in);
    hz.d_rs = in.rs; hz.d_rt = in.rt; hz.d_tuse_rs = in.tuse_rs; hz.d_tuse_rt = in.tuse_rt;
    hz.d_dst = in.dst; hz.d_tnew = in.tnew; hz.d_wen = in.wen;
    hz.d_md_start = in.md_start; hz.d_md_div = in.md_div; hz.d_md_use = in.md_use;
  endtask

  // One clock: present D, predict this cycle's outputs, then advance the model.
  task automatic step(input instr_t in, output bit stalled);
    exp_t e;
    fl_t  f;
    drive(in);
    e.busy  = model_busy();
    e.stall = need_stall(in.rs, in.tuse_rs) || need_stall(in.rt, in.tuse_rt) ||
              (in.md_use && e.busy);
    e.fdrs  = d_src(in.rs);
    e.fdrt  = d_src(in.rt);
    e.fers  = e_src(1'b0);
    e.fert  = e_src(1'b1);
    sbq.push_back(e);
    stalled = e.stall;
    @(posedge clk);
    if (!e.stall) begin
      f.dst = in.dst; f.rs = in.rs; f.rt = in.rt; f.tnew = int'(in.tnew);
      f.wen = in.wen; f.enter = cyc + 1;
      fl.push_back(f);
      if (in.md_start) md_free = cyc + 1 + (in.md_div ? DIV_CYCLES : MULT_CYCLES);
    end
    cyc++;
    while (fl.size() > 0 && cyc - fl[0].enter > 2) void'(fl.pop_front());
    #1;
  endtask

  task automatic issue(input instr_t in);
    bit s;
    int n;
    n = 0;
    do begin
      step(in, s);
      n++;
    end while (s && n < 40);
    checks++;
    if (s) begin
      errors++;
      $display("FAIL issue_timeout cyc=%0d still stalled after %0d cycles, required release", cyc, n);
    end
  endtask

  task automatic do_reset(input int n);
    drive(mk(8, 0, 8, 0, 8, 2, 1'b1, 1'b1, 1'b1, 1'b1));
    reset = 1'b1;
    repeat (n) @(posedge clk);
    fl.delete();
    md_free = 0;
    cyc++;
    #1;
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("stall",    int'(hz.stall),    int'(e.stall));
      chk("fwd_d_rs", int'(hz.fwd_d_rs), int'(e.fdrs));
      chk("fwd_d_rt", int'(hz.fwd_d_rt), int'(e.fdrt));
      chk("fwd_e_rs", int'(hz.fwd_e_rs), int'(e.fers));
      chk("fwd_e_rt", int'(hz.fwd_e_rt), int'(e.fert));
      chk("md_busy",  int'(hz.md_busy),  int'(e.busy));
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
    $fatal(1);
  end

  initial begin
    instr_t nop, rd, x;
    bit s;
    checks = 0; errors = 0; cyc = 0; md_free = 0;
    nop = mk(0, 2, 0, 2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset(2);

    // Hazardous-looking D right after reset: empty pipeline, no stall or forward
    step(mk(8, 0, 9, 0, 10, 2, 1'b1, 1'b0, 1'b0, 1'b1), s);
    issue(nop); issue(nop);

    // load-use: lw $8 then add rs=8
    issue(mk(29, 1, 0, 2, 8, 2, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(mk(8, 1, 9, 1, 10, 1, 1'b1, 1'b0, 1'b0, 1'b0));
    repeat (3) issue(nop);

    // addu $9 then beq rs=9
    issue(mk(1, 1, 2, 1, 9, 1, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(mk(9, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (3) issue(nop);

    // jal then jr $31
    issue(mk(0, 2, 0, 2, 31, 0, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(mk(31, 0, 0, 2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (3) issue(nop);

    // writes to $0 never hazard; back-to-back $5 writers, nearest wins
    issue(mk(1, 1, 0, 2, 0, 2, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(mk(0, 0, 0, 0, 6, 1, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(mk(0, 2, 0, 2, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(mk(0, 2, 0, 2, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(mk(5, 0, 5, 1, 7, 1, 1'b1, 1'b0, 1'b0, 1'b0));
    repeat (3) issue(nop);

    // div then mfhi; mult then mult
    issue(mk(1, 1, 2, 1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1));
    issue(mk(0, 2, 0, 2, 12, 1, 1'b1, 1'b0, 1'b0, 1'b1));
    issue(mk(1, 1, 2, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1));
    issue(mk(1, 1, 2, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1));
    repeat (8) issue(nop);

    // reset mid-stall, then mid-div
    issue(mk(29, 1, 0, 2, 8, 2, 1'b1, 1'b0, 1'b0, 1'b0));
    rd = mk(8, 1, 0, 2, 10, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(rd, s);
    do_reset(1);
    step(rd, s);
    issue(mk(1, 1, 2, 1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1));
    repeat (3) step(mk(0, 2, 0, 2, 12, 1, 1'b1, 1'b0, 1'b0, 1'b1), s);
    do_reset(1);
    step(mk(0, 2, 0, 2, 12, 1, 1'b1, 1'b0, 1'b0, 1'b1), s);
    issue(nop);

    // Randomized traffic over a small register file to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      x.rs       = 5'($urandom_range(0, 7));
      x.rt       = 5'($urandom_range(0, 7));
      x.tuse_rs  = 2'($urandom_range(0, 2));
      x.tuse_rt  = 2'($urandom_range(0, 2));
      x.dst      = 5'($urandom_range(0, 7));
      x.tnew     = 2'($urandom_range(0, 2));
      x.wen      = 1'($urandom_range(0, 3) != 0);
      x.md_start = 1'($urandom_range(0, 11) == 0);
      x.md_div   = 1'($urandom_range(0, 1));
      x.md_use   = x.md_start | 1'($urandom_range(0, 7) == 0);
      issue(x);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
